irq_priority_ctrl: RTL and testbench

Parametrised successor to the fixed 7-input interrupt encoder. Takes NSRC interrupt sources and latches each as pending, either on a rising edge or by level. Applies a per-source enable mask and a global enable, then presents the highest-priority pending source to the bexkat1 CPU as a registered exception code with a valid/ack handshake. Sits between the peripherals (timers, UARTs, MMU, and others) and the CPU exception input.

---
 rtl/irq_priority_ctrl.sv | 108 ++++++++++
 tb/tb_irq_priority_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_ctrl.sv
// Latches NSRC interrupt sources (edge or level), masks them and presents the highest index as a code.
// Latency: 2 edges from source to irq_valid (+2 with SYNC); held until irq_ack, then one holdoff cycle.
module irq_priority_ctrl #(
    parameter int              NSRC      = 8,
    parameter int              CODEW     = 4,
    parameter int              CODE_BASE = 1,
    parameter logic [NSRC-1:0] EDGE_MASK = '0,
    parameter int              SYNC      = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NSRC-1:0]  src_i,
    input  logic             enabled,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_wdata,
    output logic [NSRC-1:0]  mask_o,
    output logic [NSRC-1:0]  pending_o,
    output logic             irq_valid,
    output logic [CODEW-1:0] irq_code,
    input  logic             irq_ack
);

    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] s, s_prev, set_edge, clr, pending_q, pending_d, mask_q, elig;
    logic [IDXW-1:0] idx, sel_q;
    logic [CODEW-1:0] code_q;

    generate
        if (SYNC != 0) begin : g_sync
            logic [NSRC-1:0] sync1, sync2;
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    sync1 <= '0;
                    sync2 <= '0;
                end else begin
                    sync1 <= src_i;
                    sync2 <= sync1;
                end
            end
            assign s = sync2;
        end else begin : g_nosync
            assign s = src_i;
        end
    endgenerate

    // Clear only targets the presented source; OR-ing set afterwards makes a coincident edge win.
    assign set_edge  = s & ~s_prev;
    assign clr       = (state_q == PRESENT && irq_ack) ? (NSRC'(1) << sel_q) : '0;
    assign pending_d = (EDGE_MASK & ((pending_q & ~clr) | set_edge)) | (~EDGE_MASK & s);
    assign elig      = pending_q & mask_q & {NSRC{enabled}};

    always_comb begin
        idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (elig[i]) idx = IDXW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (elig != '0) state_d = PRESENT;
            PRESENT: if (irq_ack)    state_d = HOLDOFF;
            HOLDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mask_q    <= '0;
            pending_q <= '0;
            s_prev    <= '0;
            sel_q     <= '0;
            code_q    <= '0;
        end else begin
            s_prev    <= s;
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_wdata;
            // sel and code are frozen for the whole PRESENT state: no preemption.
            if (state_q == IDLE && elig != '0) begin
                sel_q  <= idx;
                code_q <= CODEW'(CODE_BASE) + CODEW'(idx);
            end else if (state_q == PRESENT && irq_ack) begin
                code_q <= '0;
            end
        end
    end

    assign mask_o    = mask_q;
    assign pending_o = pending_q;
    assign irq_valid = (state_q == PRESENT);
    assign irq_code  = code_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: expected codes are queued when stimulus is driven
// and popped when a request is presented.
module tb_irq_priority_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] src_i = '0;
    logic       enabled = 1'b1;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = '0;
    logic [7:0] mask_o;
    logic [7:0] pending_o;
    logic       irq_valid;
    logic [3:0] irq_code;
    logic       irq_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    irq_priority_ctrl #(
        .NSRC(8), .CODEW(4), .CODE_BASE(1), .EDGE_MASK(8'h0F), .SYNC(0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .src_i(src_i), .enabled(enabled),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .mask_o(mask_o),
        .pending_o(pending_o), .irq_valid(irq_valid), .irq_code(irq_code),
        .irq_ack(irq_ack)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // A request must be presented now, carrying the oldest queued code.
    task automatic expect_req(input string tag);
        chk({tag, "_valid"}, 32'(irq_valid), 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb scoreboard empty, observed code=%0d", tag, irq_code);
        end else begin
            chk({tag, "_code"}, 32'(irq_code), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic do_ack(input string tag);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk({tag, "_ack_valid"}, 32'(irq_valid), 32'd0);
        chk({tag, "_ack_code"}, 32'(irq_code), 32'd0);
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    initial begin
        // 1: reset state, single edge source, ack and return to idle
        tick(); tick();
        chk("rst_valid", 32'(irq_valid), 32'd0);
        chk("rst_code", 32'(irq_code), 32'd0);
        chk("rst_mask", 32'(mask_o), 32'd0);
        chk("rst_pending", 32'(pending_o), 32'd0);
        rst_i = 1'b1;
        write_mask(8'hFF);
        chk("t1_mask", 32'(mask_o), 32'hFF);
        src_i = 8'h04; exp_q.push_back(3);
        tick();
        src_i = 8'h00;
        chk("t1_pending", 32'(pending_o), 32'h04);
        chk("t1_not_yet", 32'(irq_valid), 32'd0);
        tick();
        expect_req("t1_req");
        tick();
        chk("t1_hold_code", 32'(irq_code), 32'd3);
        do_ack("t1");
        chk("t1_cleared", 32'(pending_o), 32'h00);
        tick();
        chk("t1_idle_a", 32'(irq_valid), 32'd0);
        tick();
        chk("t1_idle_b", 32'(irq_valid), 32'd0);

        // 2: priority between simultaneous edges, lower one retained
        src_i = 8'h09; exp_q.push_back(4); exp_q.push_back(1);
        tick();
        src_i = 8'h00;
        tick();
        expect_req("t2_first");
        do_ack("t2_first");
        chk("t2_pending_low", 32'(pending_o), 32'h01);
        tick();
        chk("t2_gap", 32'(irq_valid), 32'd0);
        tick();
        expect_req("t2_second");
        do_ack("t2_second");

        // 3: no preemption by higher-priority level source 7
        tick();
        src_i = 8'h02; exp_q.push_back(2);
        tick();
        src_i = 8'h00;
        tick();
        expect_req("t3_low");
        src_i = 8'h80; exp_q.push_back(8);
        tick(); tick();
        chk("t3_no_preempt", 32'(irq_code), 32'd2);
        do_ack("t3_low");
        tick();
        tick();
        expect_req("t3_high");
        src_i = 8'h00;
        do_ack("t3_high");
        tick(); tick();
        chk("t3_quiet", 32'(irq_valid), 32'd0);

        // 4: masked edge retained, fires once unmasked
        write_mask(8'h00);
        src_i = 8'h02;
        tick();
        src_i = 8'h00;
        tick(); tick();
        chk("t4_masked", 32'(irq_valid), 32'd0);
        chk("t4_pending", 32'(pending_o), 32'h02);
        exp_q.push_back(2);
        write_mask(8'h02);
        chk("t4_mask_edge", 32'(irq_valid), 32'd0);
        tick();
        expect_req("t4_unmasked");
        do_ack("t4");
        write_mask(8'hFF);

        // 5: level source re-presented while held, not after it drops
        src_i = 8'h20; exp_q.push_back(6);
        tick(); tick();
        expect_req("t5_first");
        exp_q.push_back(6);
        do_ack("t5_first");
        tick();
        chk("t5_holdoff_gap", 32'(irq_valid), 32'd0);
        tick();
        expect_req("t5_again");
        src_i = 8'h00;
        tick();
        chk("t5_not_withdrawn", 32'(irq_code), 32'd6);
        do_ack("t5_drop");
        tick(); tick();
        chk("t5_no_repeat", 32'(irq_valid), 32'd0);

        // 6: set wins over ack clear; reset aborts a presented request
        src_i = 8'h02; exp_q.push_back(2);
        tick();
        src_i = 8'h00;
        tick();
        expect_req("t6_first");
        src_i = 8'h02; exp_q.push_back(2);
        do_ack("t6_setwins");
        src_i = 8'h00;
        chk("t6_pending_kept", 32'(pending_o), 32'h02);
        tick(); tick();
        expect_req("t6_again");
        src_i = 8'h08;
        tick();
        src_i = 8'h00;
        chk("t6_pending_both", 32'(pending_o), 32'h0A);
        chk("t6_still_code", 32'(irq_code), 32'd2);
        chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(irq_valid), 32'd0);
        chk("t6_rst_code", 32'(irq_code), 32'd0);
        chk("t6_rst_pending", 32'(pending_o), 32'd0);
        chk("t6_rst_mask", 32'(mask_o), 32'd0);
        rst_i = 1'b1;
        tick(); tick();
        chk("t6_post_rst_idle", 32'(irq_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
